// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: ALU opcodes, operand select codes,
// flag bit positions and the multiplier FSM states.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_CMP = 4'd5,
        ALU_MOV = 4'd6,
        ALU_MUL = 4'd7,
        ALU_SLL = 4'd8,
        ALU_SLR = 4'd9,
        ALU_SRL = 4'd10,
        ALU_SRA = 4'd11
    } alu_op_e;

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_EXMEM  = 2'b01;
    localparam logic [1:0] FWD_MEMWB  = 2'b10;

    localparam logic [1:0] SRCA_FWD   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;

    localparam logic [1:0] SRCB_FWD   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_SHAMT = 2'b10;
    localparam logic [1:0] SRCB_ZERO  = 2'b11;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_mul_seq.sv
// 16x16 shift-add multiplier, one partial product per cycle; only built
// when EX_MUL_EN is defined.
module ex_mul_seq
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output mul_state_e  state
);

    // Handshake: start is sampled only in IDLE, where it latches a/b; busy is
    // high for the 16 accumulate cycles; done is high for exactly one cycle
    // with product valid, and start is ignored during that cycle.
    mul_state_e  state_next;
    logic [31:0] mcand;
    logic [15:0] mplier;
    logic [31:0] acc;
    logic [3:0]  cnt;

    always_ff @(posedge clk) begin
        if (reset) state <= MUL_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= {16'h0, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MUL_BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            MUL_IDLE: if (start) state_next = MUL_BUSY;
            MUL_BUSY: begin
                busy = 1'b1;
                if (cnt == 4'd15) state_next = MUL_DONE;
            end
            MUL_DONE: begin
                done       = 1'b1;
                state_next = MUL_IDLE;
            end
            default: state_next = MUL_IDLE;
        endcase
    end

    assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Pipeline EX stage: forwarding muxes, operand selects, 16-bit ALU and flag
// register. Define EX_MUL_EN to build the multi-cycle MUL path.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] rd1_ex,
    input  logic [15:0] rd2_ex,
    input  logic [15:0] pcinc_ex,
    input  logic [15:0] extended_d_ex,
    input  logic [3:0]  d_ex,
    input  logic [3:0]  ALUop,
    input  logic [1:0]  ALUsrcA_controll,
    input  logic [1:0]  ALUsrcB_controll,
    input  logic [1:0]  forwardingA_controll,
    input  logic [1:0]  forwardingB_controll,
    input  logic [15:0] fwd_exmem_dat,
    input  logic [15:0] fwd_memwb_dat,
    input  logic        flags_en_ex,
    output logic [15:0] alu_result_ex,
    output logic [15:0] store_dat_ex,
    output logic [3:0]  flags_ex,
    output logic        stall_ex
);

    logic [15:0] fwd_a, fwd_b, op_a, op_b, result;
    logic        flag_c, flag_v;
    logic [3:0]  flags_next, sh;
    logic [16:0] sum, diff;
    logic [31:0] shl, shr, sra, rot;

    always_comb begin
        case (forwardingA_controll)
            FWD_EXMEM: fwd_a = fwd_exmem_dat;
            FWD_MEMWB: fwd_a = fwd_memwb_dat;
            default:   fwd_a = rd1_ex;
        endcase
        case (forwardingB_controll)
            FWD_EXMEM: fwd_b = fwd_exmem_dat;
            FWD_MEMWB: fwd_b = fwd_memwb_dat;
            default:   fwd_b = rd2_ex;
        endcase
        case (ALUsrcA_controll)
            SRCA_FWD: op_a = fwd_a;
            SRCA_PC:  op_a = pcinc_ex;
            default:  op_a = 16'h0;
        endcase
        case (ALUsrcB_controll)
            SRCB_FWD:   op_b = fwd_b;
            SRCB_IMM:   op_b = extended_d_ex;
            SRCB_SHAMT: op_b = {12'h0, d_ex};
            default:    op_b = 16'h0;
        endcase
    end

    assign store_dat_ex = fwd_b;

    // Shifts work in a 32-bit window so the last bit shifted out lands in a
    // fixed position and is naturally 0 for a zero amount.
    assign sh   = op_b[3:0];
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};
    assign shl  = {16'h0, op_a} << sh;
    assign shr  = {op_a, 16'h0} >> sh;
    assign sra  = $signed({op_a, 16'h0}) >>> sh;
    assign rot  = {op_a, op_a} << sh;

`ifdef EX_MUL_EN
    logic        mul_start, mul_busy, mul_done;
    logic [31:0] mul_product;
    mul_state_e  mul_state;

    assign mul_start = (ALUop == ALU_MUL);

    ex_mul_seq u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product),
        .state   (mul_state)
    );

    assign stall_ex = ((mul_state == MUL_IDLE) && mul_start) || mul_busy;
`else
    assign stall_ex = 1'b0;
`endif

    always_comb begin
        result = 16'h0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (alu_op_e'(ALUop))
            ALU_ADD: begin
                result = sum[15:0];
                flag_c = sum[16];
                flag_v = (op_a[15] == op_b[15]) && (sum[15] != op_a[15]);
            end
            ALU_SUB, ALU_CMP: begin
                result = diff[15:0];
                flag_c = diff[16];
                flag_v = (op_a[15] != op_b[15]) && (diff[15] != op_a[15]);
            end
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_XOR: result = op_a ^ op_b;
            ALU_MOV: result = op_b;
            ALU_SLL: begin
                result = shl[15:0];
                flag_c = shl[16];
            end
            ALU_SLR: begin
                result = rot[31:16];
                flag_c = (sh != 4'd0) && rot[16];
            end
            ALU_SRL: begin
                result = shr[31:16];
                flag_c = shr[15];
            end
            ALU_SRA: begin
                result = sra[31:16];
                flag_c = sra[15];
            end
`ifdef EX_MUL_EN
            ALU_MUL: begin
                result = mul_done ? mul_product[15:0] : 16'h0;
                flag_c = mul_done && (mul_product[31:16] != 16'h0);
            end
`endif
            default: ;
        endcase
    end

    assign alu_result_ex = result;

    always_comb begin
        flags_next         = 4'b0000;
        flags_next[FLAG_S] = result[15];
        flags_next[FLAG_Z] = (result == 16'h0);
        flags_next[FLAG_C] = flag_c;
        flags_next[FLAG_V] = flag_v;
    end

    always_ff @(posedge clk) begin
        if (reset)                        flags_ex <= 4'b0000;
        else if (flags_en_ex && !stall_ex) flags_ex <= flags_next;
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage; the MUL sequence is exercised only when
// EX_MUL_EN is defined, otherwise MUL is checked as a zero-result op.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rd1_ex, rd2_ex, pcinc_ex, extended_d_ex;
  logic [3:0]  d_ex, ALUop;
  logic [1:0]  ALUsrcA_controll, ALUsrcB_controll;
  logic [1:0]  forwardingA_controll, forwardingB_controll;
  logic [15:0] fwd_exmem_dat, fwd_memwb_dat;
  logic        flags_en_ex;
  logic [15:0] alu_result_ex, store_dat_ex;
  logic [3:0]  flags_ex;
  logic        stall_ex;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [19:0] exp_q[$];
  logic [3:0]  flags_model;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .rd1_ex               (rd1_ex),
    .rd2_ex               (rd2_ex),
    .pcinc_ex             (pcinc_ex),
    .extended_d_ex        (extended_d_ex),
    .d_ex                 (d_ex),
    .ALUop                (ALUop),
    .ALUsrcA_controll     (ALUsrcA_controll),
    .ALUsrcB_controll     (ALUsrcB_controll),
    .forwardingA_controll (forwardingA_controll),
    .forwardingB_controll (forwardingB_controll),
    .fwd_exmem_dat        (fwd_exmem_dat),
    .fwd_memwb_dat        (fwd_memwb_dat),
    .flags_en_ex          (flags_en_ex),
    .alu_result_ex        (alu_result_ex),
    .store_dat_ex         (store_dat_ex),
    .flags_ex             (flags_ex),
    .stall_ex             (stall_ex)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fwd_model(input logic [1:0] sel, input logic [15:0] regv);
    if (sel == 2'b01) return fwd_exmem_dat;
    if (sel == 2'b10) return fwd_memwb_dat;
    return regv;
  endfunction

  // Reference ALU: integer arithmetic and bit-at-a-time shifting.
  function automatic logic [19:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        c, v;
    int          u, s;
    logic [31:0] p;
    r = 16'h0; c = 1'b0; v = 1'b0; p = 32'h0;
    case (op)
      4'd0: begin
        u = int'(a) + int'(b);
        s = int'($signed(a)) + int'($signed(b));
        r = u[15:0]; c = (u > 65535); v = (s > 32767) || (s < -32768);
      end
      4'd1, 4'd5: begin
        u = int'(a) - int'(b);
        s = int'($signed(a)) - int'($signed(b));
        r = u[15:0]; c = (a < b); v = (s > 32767) || (s < -32768);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd6: r = b;
      4'd7: begin
`ifdef EX_MUL_EN
        p = {16'h0, a} * {16'h0, b};
        r = p[15:0]; c = (p[31:16] != 16'h0);
`endif
      end
      4'd8: begin
        r = a;
        for (int i = 0; i < int'(b[3:0]); i++) begin c = r[15]; r = {r[14:0], 1'b0}; end
      end
      4'd9: begin
        r = a;
        for (int i = 0; i < int'(b[3:0]); i++) begin c = r[15]; r = {r[14:0], r[15]}; end
      end
      4'd10: begin
        r = a;
        for (int i = 0; i < int'(b[3:0]); i++) begin c = r[0]; r = {1'b0, r[15:1]}; end
      end
      4'd11: begin
        r = a;
        for (int i = 0; i < int'(b[3:0]); i++) begin c = r[0]; r = {r[15], r[15:1]}; end
      end
      default: r = 16'h0;
    endcase
    return {r, r[15], (r == 16'h0), c, v};
  endfunction

  task automatic set_basic(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    ALUop = op; rd1_ex = a; rd2_ex = b;
    forwardingA_controll = 2'b00; forwardingB_controll = 2'b00;
    ALUsrcA_controll = 2'b00; ALUsrcB_controll = 2'b00;
    flags_en_ex = 1'b1;
  endtask

  // Entered at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic apply_op(input string tag);
    logic [15:0] fa, fb, oa, ob;
    logic [19:0] e, item;
    fa = fwd_model(forwardingA_controll, rd1_ex);
    fb = fwd_model(forwardingB_controll, rd2_ex);
    case (ALUsrcA_controll)
      2'b00: oa = fa;
      2'b01: oa = pcinc_ex;
      default: oa = 16'h0;
    endcase
    case (ALUsrcB_controll)
      2'b00: ob = fb;
      2'b01: ob = extended_d_ex;
      2'b10: ob = {12'h0, d_ex};
      default: ob = 16'h0;
    endcase
    e = alu_model(ALUop, oa, ob);
    if (flags_en_ex) flags_model = e[3:0];
    exp_q.push_back({e[19:4], flags_model});
    #3;
    check_eq({tag, "_res"}, 32'(alu_result_ex), 32'(exp_q[0][19:4]));
    check_eq({tag, "_store"}, 32'(store_dat_ex), 32'(fb));
    check_eq({tag, "_stall"}, 32'(stall_ex), 32'h0);
    @(posedge clk); #1;
    item = exp_q.pop_front();
    check_eq({tag, "_flags"}, 32'(flags_ex), 32'(item[3:0]));
  endtask

`ifdef EX_MUL_EN
  // Entered at posedge+1 in the launch cycle; returns at posedge+1 after DONE.
  task automatic run_mul(input string tag, input logic change_ops);
    logic [31:0] p;
    logic [19:0] item;
    int          cycles;
    p = {16'h0, rd1_ex} * {16'h0, rd2_ex};
    exp_q.push_back({p[15:0], p[15], (p[15:0] == 16'h0), (p[31:16] != 16'h0), 1'b0});
    cycles = 0;
    while (stall_ex && cycles < 40) begin
      cycles++;
      if (change_ops && cycles == 5) begin
        rd1_ex = 16'($urandom); rd2_ex = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    check_eq({tag, "_stall_cycles"}, 32'(cycles), 32'd17);
    check_eq({tag, "_res"}, 32'(alu_result_ex), 32'(exp_q[0][19:4]));
    check_eq({tag, "_flags_held"}, 32'(flags_ex), 32'(flags_model));
    @(posedge clk); #1;
    item = exp_q.pop_front();
    flags_model = item[3:0];
    check_eq({tag, "_flags"}, 32'(flags_ex), 32'(item[3:0]));
  endtask
`endif

  initial begin
    reset = 1'b1;
    set_basic(4'd0, 16'h0, 16'h0);
    pcinc_ex = 16'h0; extended_d_ex = 16'h0; d_ex = 4'h0;
    fwd_exmem_dat = 16'h0; fwd_memwb_dat = 16'h0;
    flags_model = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_flags", 32'(flags_ex), 32'h0);
    check_eq("reset_stall", 32'(stall_ex), 32'h0);
    reset = 1'b0;

    // Signed overflow on ADD.
    set_basic(4'd0, 16'h7FFF, 16'h0001);
    apply_op("add_ovf");
    check_eq("add_ovf_const_res", 32'(alu_result_ex), 32'h8000);
    check_eq("add_ovf_const_flags", 32'(flags_ex), 32'h9);

    // Flags hold when the flag enable is low.
    set_basic(4'd5, 16'h4444, 16'h4444);
    flags_en_ex = 1'b0;
    apply_op("cmp_noflag");
    check_eq("cmp_noflag_const", 32'(flags_ex), 32'h9);

    // Forwarding from EX/MEM and MEM/WB.
    set_basic(4'd1, 16'hDEAD, 16'h1234);
    forwardingA_controll = 2'b01; fwd_exmem_dat = 16'h1234;
    apply_op("sub_fwd_exmem");
    check_eq("sub_fwd_exmem_const", 32'(flags_ex), 32'h4);
    forwardingA_controll = 2'b10; fwd_memwb_dat = 16'h2000;
    apply_op("sub_fwd_memwb");
    check_eq("sub_fwd_memwb_const", 32'(alu_result_ex), 32'h0DCC);
    forwardingA_controll = 2'b11; forwardingB_controll = 2'b01;
    apply_op("sub_fwdb_exmem");

    // Operand source selects.
    set_basic(4'd0, 16'h1111, 16'h2222);
    ALUsrcA_controll = 2'b01; pcinc_ex = 16'h0101;
    ALUsrcB_controll = 2'b01; extended_d_ex = 16'hFFFF;
    apply_op("add_pc_imm");
    ALUsrcA_controll = 2'b10; ALUsrcB_controll = 2'b11;
    apply_op("add_zero_zero");

    // Shifts and rotate.
    set_basic(4'd11, 16'h8001, 16'h0);
    ALUsrcB_controll = 2'b10; d_ex = 4'd1;
    apply_op("sra1");
    check_eq("sra1_const", 32'(alu_result_ex), 32'hC000);
    check_eq("sra1_const_flags", 32'(flags_ex), 32'hA);
    ALUop = 4'd9; d_ex = 4'd4;
    apply_op("slr4");
    check_eq("slr4_const", 32'(alu_result_ex), 32'h0018);
    ALUop = 4'd8; d_ex = 4'd0;
    apply_op("sll0");
    ALUop = 4'd10; d_ex = 4'd15;
    apply_op("srl15");

`ifdef EX_MUL_EN
    set_basic(4'd7, 16'h0123, 16'h0010);
    run_mul("mul1", 1'b0);
    check_eq("mul1_const_res_idle", 32'(stall_ex), 32'h1);
    rd1_ex = 16'hFFFF; rd2_ex = 16'h0002;
    run_mul("mul2_b2b", 1'b1);

    set_basic(4'd0, 16'h7FFF, 16'h0001);
    apply_op("add_pre_rst");
    set_basic(4'd7, 16'h0005, 16'h0007);
    repeat (8) @(posedge clk);
    #1;
    check_eq("busy8_stall", 32'(stall_ex), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    flags_model = 4'b0000;
    exp_q.delete();
    check_eq("rst_busy_flags", 32'(flags_ex), 32'h0);
    check_eq("rst_busy_stall", 32'(stall_ex), 32'h1);
    rd1_ex = 16'h8000; rd2_ex = 16'h0003;
    run_mul("mul_after_rst", 1'b0);
    check_eq("mul_after_rst_const", 32'(flags_ex), 32'hA);
    set_basic(4'd2, 16'h0F0F, 16'h00FF);
    apply_op("and_after_mul");
`else
    set_basic(4'd7, 16'h0123, 16'h0010);
    apply_op("mul_disabled");
    check_eq("mul_disabled_const", 32'(flags_ex), 32'h4);
`endif

    for (int i = 0; i < 40; i++) begin
      ALUop = 4'($urandom_range(0, 15));
`ifdef EX_MUL_EN
      if (ALUop == 4'd7) ALUop = 4'd4;
`endif
      rd1_ex = 16'($urandom); rd2_ex = 16'($urandom);
      pcinc_ex = 16'($urandom); extended_d_ex = 16'($urandom);
      fwd_exmem_dat = 16'($urandom); fwd_memwb_dat = 16'($urandom);
      d_ex = 4'($urandom_range(0, 15));
      forwardingA_controll = 2'($urandom_range(0, 3));
      forwardingB_controll = 2'($urandom_range(0, 3));
      ALUsrcA_controll = 2'($urandom_range(0, 3));
      ALUsrcB_controll = 2'($urandom_range(0, 3));
      flags_en_ex = 1'($urandom_range(0, 1));
      apply_op($sformatf("rand%0d_op%0d", i, ALUop));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
